// File: rtl/r5fp_int_div_sqrt_seq_if.sv
// Handshake bundle between an FP divide/sqrt front-end and the iterative
// integer divide / square-root engine. The front-end is the master, the
// engine the slave.
interface r5fp_int_div_sqrt_seq_if #(
    parameter int W = 26
);
    logic [W-1:0] N_i;
    logic [W-1:0] D_i;
    logic         is_div_i;
    logic         strobe_i;
    logic [W-1:0] Quo_o;
    logic [W-1:0] Rem_o;
    logic         done_o;
    logic         ready_o;

    modport master (
        output N_i, D_i, is_div_i, strobe_i,
        input  Quo_o, Rem_o, done_o, ready_o
    );

    modport slave (
        input  N_i, D_i, is_div_i, strobe_i,
        output Quo_o, Rem_o, done_o, ready_o
    );
endinterface

// File: rtl/r5fp_int_div_sqrt_seq.sv
// Iterative radix-2 integer divide / square-root engine.
// Divide: restoring, Quo = floor(N*2^(W-1)/D), Rem = N*2^(W-1) mod D, W steps.
// Sqrt:   restoring digit-by-digit on {D, (W-2) zeros}, W-1 steps.
// One quotient/root bit per clock; results are held until the next operation
// completes, and done pulses for one cycle when they change.
module r5fp_int_div_sqrt_seq #(
    parameter int W = 26
) (
    input  logic                   clk,
    input  logic                   reset,
    r5fp_int_div_sqrt_seq_if.slave bus
);
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] DIV_STEPS  = CW'(W);
    localparam logic [CW-1:0] SQRT_STEPS = CW'(W - 1);
    localparam logic [CW-1:0] ONE_STEP   = CW'(1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [W:0]    r;
    logic [W:0]    r_step;
    logic [W:0]    r_sub;
    logic [W:0]    r_sh;
    logic [W:0]    trial;
    logic [W-1:0]  q;
    logic [W-1:0]  q_step;
    logic [W-1:0]  d_reg;
    logic [W-1:0]  rad;
    logic          is_div;
    logic          start;
    logic          last_step;

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: accept a strobe only when idle, return after the final step.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.strobe_i) state_next = BUSY;
            BUSY:    if (cnt == ONE_STEP) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decoded outputs of the FSM: ready, operation start and final-step flag.
    always_comb begin
        bus.ready_o = (state == IDLE);
        start       = (state == IDLE) && bus.strobe_i;
        last_step   = (state == BUSY) && (cnt == ONE_STEP);
    end

    // One iteration of either recurrence, computed from the current state.
    // The divide remainder is not shifted on its last step so that it is
    // directly the final remainder; sqrt pulls the next radicand pair from
    // the top of rad, which shifts in zeros once D is exhausted.
    always_comb begin
        r_sub  = r - {1'b0, d_reg};
        r_sh   = (r << 2) | {{(W-1){1'b0}}, rad[W-1 -: 2]};
        trial  = ({1'b0, q} << 2) | {{W{1'b0}}, 1'b1};
        r_step = r;
        q_step = q;
        if (is_div) begin
            if (r >= {1'b0, d_reg}) begin
                q_step = {q[W-2:0], 1'b1};
                r_step = last_step ? r_sub : (r_sub << 1);
            end else begin
                q_step = {q[W-2:0], 1'b0};
                r_step = last_step ? r : (r << 1);
            end
        end else begin
            if (r_sh >= trial) begin
                q_step = {q[W-2:0], 1'b1};
                r_step = r_sh - trial;
            end else begin
                q_step = {q[W-2:0], 1'b0};
                r_step = r_sh;
            end
        end
    end

    // Datapath: latch operands on start, iterate while busy, publish results
    // and pulse done on the final step. Divide-by-zero naturally yields an
    // all-ones quotient; its remainder is forced to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            r          <= '0;
            q          <= '0;
            d_reg      <= '0;
            rad        <= '0;
            is_div     <= 1'b0;
            bus.Quo_o  <= '0;
            bus.Rem_o  <= '0;
            bus.done_o <= 1'b0;
        end else begin
            bus.done_o <= 1'b0;
            if (start) begin
                r      <= bus.is_div_i ? {1'b0, bus.N_i} : '0;
                q      <= '0;
                d_reg  <= bus.D_i;
                rad    <= bus.D_i;
                is_div <= bus.is_div_i;
                cnt    <= bus.is_div_i ? DIV_STEPS : SQRT_STEPS;
            end else if (state == BUSY) begin
                r   <= r_step;
                q   <= q_step;
                rad <= rad << 2;
                cnt <= cnt - ONE_STEP;
                if (last_step) begin
                    bus.Quo_o  <= q_step;
                    bus.Rem_o  <= (is_div && (d_reg == '0)) ? '0 : r_step[W-1:0];
                    bus.done_o <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_r5fp_int_div_sqrt_seq.sv
// Self-checking bench for r5fp_int_div_sqrt_seq: directed W=8 scenarios plus
// randomized W=26 operations against a plain big-integer reference model.
module tb_r5fp_int_div_sqrt_seq;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    r5fp_int_div_sqrt_seq_if #(.W(8))  bus8 ();
    r5fp_int_div_sqrt_seq_if #(.W(26)) bus26 ();

    r5fp_int_div_sqrt_seq #(.W(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));
    r5fp_int_div_sqrt_seq #(.W(26)) dut26 (.clk(clk), .reset(reset), .bus(bus26));

    // Reference divide: floor(N*2^(w-1)/D) and remainder; D=0 gives all ones / 0.
    function automatic void ref_div(input int w, input longint n, input longint d,
                                    output longint q, output longint r);
        longint num;
        if (d == 0) begin
            q = (longint'(1) << w) - 1;
            r = 0;
        end else begin
            num = n << (w - 1);
            q = num / d;
            r = num % d;
        end
    endfunction

    // Reference sqrt: largest x with x*x <= D*2^(w-2), found by bisection.
    function automatic void ref_sqrt(input int w, input longint d,
                                     output longint q, output longint r);
        longint v, lo, hi, mid;
        v  = d << (w - 2);
        lo = 0;
        hi = longint'(1) << w;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid;
        end
        q = lo;
        r = v - lo * lo;
    endfunction

    // Random operands meeting the divide precondition N < 2D (occasional D=0).
    task automatic gen_op(input int w, output longint n, output longint d, output logic is_div);
        longint mask, n_max;
        mask   = (longint'(1) << w) - 1;
        is_div = 1'($urandom_range(0, 1));
        d      = longint'($urandom) & mask;
        if ($urandom_range(0, 3) == 0) d = d | (longint'(1) << (w - 1));
        n = 0;
        if (is_div) begin
            if ($urandom_range(0, 31) == 0) d = 0;
            if (d == 0) n_max = mask;
            else n_max = (2 * d - 1 < mask) ? 2 * d - 1 : mask;
            n = longint'($urandom) % (n_max + 1);
        end
    endtask

    // Drives one W=8 operation and waits (bounded) for done; lat counts
    // cycles after the strobe cycle. Inputs are scrambled after capture.
    task automatic run_op8(input logic [7:0] n, input logic [7:0] d, input logic is_div,
                           output logic [7:0] q, output logic [7:0] r,
                           output int lat, output logic timed_out);
        @(posedge clk); #1;
        bus8.N_i = n; bus8.D_i = d; bus8.is_div_i = is_div; bus8.strobe_i = 1'b1;
        @(posedge clk); #1;
        bus8.strobe_i = 1'b0;
        bus8.N_i = 8'($urandom); bus8.D_i = 8'($urandom); bus8.is_div_i = 1'($urandom);
        lat = 1;
        while (bus8.done_o !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        timed_out = (bus8.done_o !== 1'b1);
        q = bus8.Quo_o;
        r = bus8.Rem_o;
    endtask

    task automatic run_op26(input logic [25:0] n, input logic [25:0] d, input logic is_div,
                            output logic [25:0] q, output logic [25:0] r,
                            output int lat, output logic timed_out);
        @(posedge clk); #1;
        bus26.N_i = n; bus26.D_i = d; bus26.is_div_i = is_div; bus26.strobe_i = 1'b1;
        @(posedge clk); #1;
        bus26.strobe_i = 1'b0;
        bus26.N_i = 26'($urandom); bus26.D_i = 26'($urandom); bus26.is_div_i = 1'($urandom);
        lat = 1;
        while (bus26.done_o !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        timed_out = (bus26.done_o !== 1'b1);
        q = bus26.Quo_o;
        r = bus26.Rem_o;
    endtask

    task automatic test_reset();
        logic [7:0] q, r;
        int lat, dones;
        logic to;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus8.ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", bus8.ready_o); end
        checks++; if (bus8.done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus8.done_o); end
        checks++; if (bus8.Quo_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_quo: got %h expected 00", bus8.Quo_o); end
        checks++; if (bus8.Rem_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_rem: got %h expected 00", bus8.Rem_o); end
        reset = 1'b0;
        run_op8(8'h01, 8'h03, 1'b1, q, r, lat, to);
        checks++; if (to || q !== 8'h2A) begin errors++; $display("[TB] FAIL pre_reset_quo: got %h expected 2a", q); end
        // start a divide and reset it three edges after the strobe edge
        @(posedge clk); #1;
        bus8.N_i = 8'h90; bus8.D_i = 8'hC0; bus8.is_div_i = 1'b1; bus8.strobe_i = 1'b1;
        @(posedge clk); #1;
        bus8.strobe_i = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (bus8.done_o !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done: got %b expected 0", bus8.done_o); end
        checks++; if (bus8.ready_o !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready: got %b expected 1", bus8.ready_o); end
        checks++; if (bus8.Quo_o !== 8'h00) begin errors++; $display("[TB] FAIL midreset_quo: got %h expected 00", bus8.Quo_o); end
        checks++; if (bus8.Rem_o !== 8'h00) begin errors++; $display("[TB] FAIL midreset_rem: got %h expected 00", bus8.Rem_o); end
        @(posedge clk); #1;
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus8.done_o === 1'b1) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("[TB] FAIL midreset_no_done: got %0d pulses expected 0", dones); end
        checks++; if (bus8.ready_o !== 1'b1) begin errors++; $display("[TB] FAIL postreset_ready: got %b expected 1", bus8.ready_o); end
    endtask

    task automatic test_divide();
        logic [7:0] q, r;
        int lat;
        logic to;
        run_op8(8'h90, 8'hC0, 1'b1, q, r, lat, to);
        checks++; if (to || lat != 9) begin errors++; $display("[TB] FAIL div_latency: got %0d expected 9", lat); end
        checks++; if (q !== 8'h60) begin errors++; $display("[TB] FAIL div_quo_90_c0: got %h expected 60", q); end
        checks++; if (r !== 8'h00) begin errors++; $display("[TB] FAIL div_rem_90_c0: got %h expected 00", r); end
        run_op8(8'h01, 8'h03, 1'b1, q, r, lat, to);
        checks++; if (to || q !== 8'h2A) begin errors++; $display("[TB] FAIL div_quo_01_03: got %h expected 2a", q); end
        checks++; if (r !== 8'h02) begin errors++; $display("[TB] FAIL div_rem_01_03: got %h expected 02", r); end
    endtask

    task automatic test_sqrt();
        logic [7:0] q, r;
        int lat;
        logic to;
        run_op8(8'h00, 8'h40, 1'b0, q, r, lat, to);
        checks++; if (to || lat != 8) begin errors++; $display("[TB] FAIL sqrt_latency: got %0d expected 8", lat); end
        checks++; if (q !== 8'h40) begin errors++; $display("[TB] FAIL sqrt_quo_40: got %h expected 40", q); end
        checks++; if (r !== 8'h00) begin errors++; $display("[TB] FAIL sqrt_rem_40: got %h expected 00", r); end
        run_op8(8'hA5, 8'hFF, 1'b0, q, r, lat, to);
        checks++; if (to || q !== 8'h7F) begin errors++; $display("[TB] FAIL sqrt_quo_ff: got %h expected 7f", q); end
        checks++; if (r !== 8'hBF) begin errors++; $display("[TB] FAIL sqrt_rem_ff: got %h expected bf", r); end
    endtask

    task automatic test_div_by_zero();
        logic [7:0] q, r;
        int lat;
        logic to;
        run_op8(8'h05, 8'h00, 1'b1, q, r, lat, to);
        checks++; if (to || lat != 9) begin errors++; $display("[TB] FAIL divzero_latency: got %0d expected 9", lat); end
        checks++; if (q !== 8'hFF) begin errors++; $display("[TB] FAIL divzero_quo: got %h expected ff", q); end
        checks++; if (r !== 8'h00) begin errors++; $display("[TB] FAIL divzero_rem: got %h expected 00", r); end
    endtask

    task automatic test_back_to_back();
        localparam int NOPS = 8;
        longint n[NOPS], d[NOPS], eq[NOPS], er[NOPS];
        logic   dv[NOPS];
        int     idx, cyc, since, extra;
        for (int i = 0; i < NOPS; i++) begin
            gen_op(8, n[i], d[i], dv[i]);
            if (dv[i]) ref_div(8, n[i], d[i], eq[i], er[i]);
            else ref_sqrt(8, d[i], eq[i], er[i]);
        end
        @(posedge clk); #1;
        bus8.N_i = 8'(n[0]); bus8.D_i = 8'(d[0]); bus8.is_div_i = dv[0]; bus8.strobe_i = 1'b1;
        idx = 0; cyc = 0; since = 0;
        while (idx < NOPS && cyc < 400) begin
            @(posedge clk); #1;
            cyc++; since++;
            if (bus8.done_o === 1'b1) begin
                checks++; if (longint'(bus8.Quo_o) !== eq[idx]) begin errors++; $display("[TB] FAIL b2b_quo[%0d]: got %h expected %h", idx, bus8.Quo_o, eq[idx]); end
                checks++; if (longint'(bus8.Rem_o) !== er[idx]) begin errors++; $display("[TB] FAIL b2b_rem[%0d]: got %h expected %h", idx, bus8.Rem_o, er[idx]); end
                checks++; if (since != (dv[idx] ? 9 : 8)) begin errors++; $display("[TB] FAIL b2b_spacing[%0d]: got %0d expected %0d", idx, since, dv[idx] ? 9 : 8); end
                idx++; since = 0;
                if (idx < NOPS) begin
                    bus8.N_i = 8'(n[idx]); bus8.D_i = 8'(d[idx]); bus8.is_div_i = dv[idx];
                end else begin
                    bus8.strobe_i = 1'b0;
                end
            end
        end
        bus8.strobe_i = 1'b0;
        checks++; if (idx != NOPS) begin errors++; $display("[TB] FAIL b2b_timeout: got %0d done pulses expected %0d", idx, NOPS); end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus8.done_o === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("[TB] FAIL b2b_extra_done: got %0d expected 0", extra); end
    endtask

    task automatic test_busy_strobe();
        logic [7:0] q, r;
        int lat, extra;
        logic to;
        run_op8(8'h00, 8'h40, 1'b0, q, r, lat, to);
        checks++; if (to || q !== 8'h40) begin errors++; $display("[TB] FAIL busy_pre_quo: got %h expected 40", q); end
        @(posedge clk); #1;
        bus8.N_i = 8'h90; bus8.D_i = 8'hC0; bus8.is_div_i = 1'b1; bus8.strobe_i = 1'b1;
        @(posedge clk); #1;
        bus8.strobe_i = 1'b0;
        lat = 1;
        while (bus8.done_o !== 1'b1 && lat < 40) begin
            checks++; if (bus8.Quo_o !== 8'h40 || bus8.Rem_o !== 8'h00) begin errors++; $display("[TB] FAIL busy_hold[%0d]: got %h/%h expected 40/00", lat, bus8.Quo_o, bus8.Rem_o); end
            if (lat == 2 || lat == 4 || lat == 6) begin
                bus8.N_i = 8'($urandom); bus8.D_i = 8'hFF; bus8.is_div_i = 1'b0; bus8.strobe_i = 1'b1;
            end else begin
                bus8.strobe_i = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus8.strobe_i = 1'b0;
        checks++; if (bus8.done_o !== 1'b1 || lat != 9) begin errors++; $display("[TB] FAIL busy_latency: got %0d expected 9", lat); end
        checks++; if (bus8.Quo_o !== 8'h60) begin errors++; $display("[TB] FAIL busy_quo: got %h expected 60", bus8.Quo_o); end
        checks++; if (bus8.Rem_o !== 8'h00) begin errors++; $display("[TB] FAIL busy_rem: got %h expected 00", bus8.Rem_o); end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus8.done_o === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("[TB] FAIL busy_not_queued: got %0d pulses expected 0", extra); end
    endtask

    task automatic test_random();
        localparam int NR = 1200;
        longint n, d, eq, er;
        logic dv, to;
        logic [25:0] q, r;
        int lat;
        for (int i = 0; i < NR; i++) begin
            gen_op(26, n, d, dv);
            if (dv) ref_div(26, n, d, eq, er);
            else ref_sqrt(26, d, eq, er);
            run_op26(26'(n), 26'(d), dv, q, r, lat, to);
            checks++; if (to || lat != (dv ? 27 : 26)) begin errors++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, dv ? 27 : 26); end
            checks++; if (longint'(q) !== eq) begin errors++; $display("[TB] FAIL rand_quo[%0d] div=%b n=%h d=%h: got %h expected %h", i, dv, n, d, q, eq); end
            checks++; if (longint'(r) !== er) begin errors++; $display("[TB] FAIL rand_rem[%0d] div=%b n=%h d=%h: got %h expected %h", i, dv, n, d, r, er); end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus8.N_i = '0;  bus8.D_i = '0;  bus8.is_div_i = 1'b0;  bus8.strobe_i = 1'b0;
        bus26.N_i = '0; bus26.D_i = '0; bus26.is_div_i = 1'b0; bus26.strobe_i = 1'b0;
        test_reset();
        test_divide();
        test_sqrt();
        test_div_by_zero();
        test_back_to_back();
        test_busy_strobe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
